flip_dispatch: RTL and testbench
================================

FLIP_DISPATCH -- requirements
Module: flip_dispatch

Interface
REQ-001 Parameter: DEPTH, 4, FIFO entries holding selected flip indices; power of two, 2..16.
REQ-002 Parameter: NOFLIP_LIMIT, 16, consecutive no-candidate cycles before an offset-increment pulse; 2..255.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_index  input  10  winning spin index from the priority selector tree.
REQ-006 Port: in_valid  input  1  selector tree reports at least one flip candidate this cycle.
REQ-007 Port: in_ready  output  1  block can accept in_index this cycle.
REQ-008 Port: out_index  output  10  head-of-queue index to the spin-update stage.
REQ-009 Port: out_valid  output  1  out_index is valid.
REQ-010 Port: out_ready  input  1  spin-update stage consumes out_index this cycle.
REQ-011 Port: flush  input  1  request to stop accepting and drain the queue.
REQ-012 Port: flush_done  output  1  one-cycle pulse when a drain completes.
REQ-013 Port: offset_inc  output  1  one-cycle pulse requesting a dynamic-offset increment.
REQ-014 Port: offset_clr  output  1  one-cycle pulse requesting a dynamic-offset clear.

Function
REQ-015 Push: a push SHALL occur when in_valid && in_ready; pop when out_valid && out_ready.
REQ-016 FIFO: in_ready = !full && state==RUN; out_valid = !empty; out_index = head entry, driven from registers.
REQ-017 Latency: a pushed index SHALL be visible on out_index one cycle after the push when the FIFO was empty.
REQ-018 Ordering: indices SHALL pop in push order; the occupancy counter is log2(DEPTH)+1 bits; read/write pointers wrap modulo DEPTH.
REQ-019 Simultaneous push/pop when neither full nor empty: occupancy unchanged, both pointers advance.
REQ-020 Full: in_ready low, and an in_valid while full is dropped, not stored; empty: out_valid low, out_index holds its last value.
REQ-021 No-flip counter: increments each cycle in_valid==0 in RUN; cleared on any cycle in_valid==1.
REQ-022 Offset increment: on the cycle the counter equals NOFLIP_LIMIT-1 with in_valid==0, offset_inc SHALL pulse for one cycle (registered, next cycle) and the counter SHALL return to 0.
REQ-023 Offset clear: offset_clr SHALL pulse for one cycle (registered, next cycle) after every pop.
REQ-024 FSM states: RUN and DRAIN.
REQ-025 RUN -> DRAIN when flush==1.
REQ-026 DRAIN: in_ready forced 0; pops continue; no-flip counter held at 0; offset_inc suppressed.
REQ-027 DRAIN -> RUN on the cycle after the FIFO becomes empty, with flush_done pulsing for one cycle on that transition.
REQ-028 Flush while already empty: flush_done SHALL pulse in the cycle after the flush is sampled.
REQ-029 Flush held high: flush is level-insensitive once in DRAIN; re-flush after return to RUN repeats the sequence.

Reset
REQ-030 With rst_n==0 at a clock edge: state=RUN, FIFO empty, pointers=0, no-flip counter=0, out_index=0, out_valid=0, in_ready=1 (first cycle after reset), offset_inc=0, offset_clr=0, flush_done=0.
REQ-031 Reset mid-drain or mid-transfer SHALL discard all queued indices with no pulse emitted.

Configuration
REQ-032 Macro FLIP_DISPATCH_STATS_EN defined: an extra output port flip_count (output, 16 bits) counts pops, saturates at 16'hFFFF, and is cleared by reset only.
REQ-033 FLIP_DISPATCH_STATS_EN undefined: port flip_count and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Push idx 5, 9, 1023 back-to-back with out_ready=1 -> out_index 5, 9, 1023 on consecutive cycles starting 1 cycle after the first push; three offset_clr pulses.
REQ-035 out_ready=0, in_valid=1 for 6 cycles (DEPTH=4) -> in_ready low after the 4th push; the 5th and 6th are dropped; subsequent pops yield only the first 4 indices.
REQ-036 in_valid=0 for 40 cycles (NOFLIP_LIMIT=16) -> exactly 2 offset_inc pulses, at cycles 17 and 33; in_valid=1 at cycle 10 of a second run -> counter restarts.
REQ-037 FIFO holding 3 entries, flush=1, out_ready=1 -> in_ready=0; 3 pops; flush_done a single pulse the cycle after empty; state back in RUN.
REQ-038 Assert rst_n=0 with 2 queued entries during DRAIN -> next cycle out_valid=0, in_ready=1, no flush_done.
REQ-039 With FLIP_DISPATCH_STATS_EN, force 70000 pops -> flip_count = 16'hFFFF; without the macro, the build elaborates with no flip_count port.

Source files
------------

// File: rtl/flip_dispatch.sv
// Flip-index dispatch queue: FIFO between the priority selector and spin update, with offset pulses and flush/drain.
// Optional build macro FLIP_DISPATCH_STATS_EN adds a saturating pop counter port flip_count.
module flip_dispatch #(
   parameter int DEPTH        = 4,
   parameter int NOFLIP_LIMIT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] in_index,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [9:0] out_index,
   output logic       out_valid,
   input  logic       out_ready,
   input  logic       flush,
   output logic       flush_done,
   output logic       offset_inc,
`ifdef FLIP_DISPATCH_STATS_EN
   output logic       offset_clr,
   output logic [15:0] flip_count
`else
   output logic       offset_clr
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;

   logic [9:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_nxt;
   logic [CW-1:0] count, count_after_pop, count_nxt;
   logic [7:0]    noflip_cnt;
   logic [0:0]    state;
   logic          push, pop, full, empty;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign in_ready  = !full && (state == ST_RUN);
   assign out_valid = !empty;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign rd_ptr_nxt      = rd_ptr + AW'(pop);
   assign count_after_pop = count - CW'(pop);
   assign count_nxt       = count_after_pop + CW'(push);

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_index;
   end

   // Head register: bypass the incoming index when the queue would otherwise be empty, hold when it drains
   always_ff @(posedge clk) begin
      if (!rst_n)
         out_index <= '0;
      else if (push && (count_after_pop == '0))
         out_index <= in_index;
      else if (count_nxt != '0)
         out_index <= mem[rd_ptr_nxt];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         noflip_cnt <= '0;
         offset_inc <= 1'b0;
         offset_clr <= 1'b0;
         flush_done <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr     <= rd_ptr_nxt;
         count      <= count_nxt;
         offset_clr <= pop;
         offset_inc <= 1'b0;
         flush_done <= 1'b0;
         case (state)
            ST_RUN: begin
               if (in_valid)
                  noflip_cnt <= '0;
               else if (noflip_cnt == 8'(NOFLIP_LIMIT - 1)) begin
                  noflip_cnt <= '0;
                  offset_inc <= 1'b1;
               end else
                  noflip_cnt <= noflip_cnt + 8'd1;
               // An already-empty queue completes its flush without visiting DRAIN
               if (flush) begin
                  if (empty && !push)
                     flush_done <= 1'b1;
                  else
                     state <= ST_DRAIN;
               end
            end
            default: begin
               noflip_cnt <= '0;
               if (empty) begin
                  state      <= ST_RUN;
                  flush_done <= 1'b1;
               end
            end
         endcase
      end
   end

`ifdef FLIP_DISPATCH_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst_n)
         flip_count <= '0;
      else if (pop && (flip_count != 16'hFFFF))
         flip_count <= flip_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_flip_dispatch.sv
// Directed bench for flip_dispatch: vector table for FIFO behaviour plus sequences for offsets, drain and reset.
module tb_flip_dispatch;
   localparam int DEPTH        = 4;
   localparam int NOFLIP_LIMIT = 16;
   localparam int NVEC         = 24;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] in_index = '0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [9:0] out_index;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       flush = 1'b0;
   logic       flush_done;
   logic       offset_inc;
   logic       offset_clr;
`ifdef FLIP_DISPATCH_STATS_EN
   logic [15:0] flip_count;
`endif

   int tests = 0;
   int fails = 0;

   typedef struct {
      int iv, idx, ordy, fl;
      int ov, oi, ir, clr, inc, fd;
   } vec_t;

   vec_t vecs [NVEC];

   flip_dispatch #(.DEPTH(DEPTH), .NOFLIP_LIMIT(NOFLIP_LIMIT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_index   (in_index),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_index  (out_index),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .flush      (flush),
      .flush_done (flush_done),
      .offset_inc (offset_inc),
`ifdef FLIP_DISPATCH_STATS_EN
      .offset_clr (offset_clr),
      .flip_count (flip_count)
`else
      .offset_clr (offset_clr)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      in_index = '0;
      out_ready = 1'b0;
      flush = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic push_n(input int n, input int base);
      out_ready = 1'b0;
      for (int k = 0; k < n; k++) begin
         in_valid = 1'b1;
         in_index = 10'(base + k);
         step();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int npulse, nclr, nfd;

      //            iv  idx  ordy fl | ov  oi  ir clr inc fd
      vecs[0]  = '{1,   5,   1,   0,   1,   5,  1, 0, 0, 0};
      vecs[1]  = '{1,   9,   1,   0,   1,   9,  1, 1, 0, 0};
      vecs[2]  = '{1,   1023,1,   0,   1,1023,  1, 1, 0, 0};
      vecs[3]  = '{0,   0,   1,   0,   0,1023,  1, 1, 0, 0};
      vecs[4]  = '{0,   0,   0,   0,   0,1023,  1, 0, 0, 0};
      vecs[5]  = '{1,   11,  0,   0,   1,  11,  1, 0, 0, 0};
      vecs[6]  = '{1,   12,  0,   0,   1,  11,  1, 0, 0, 0};
      vecs[7]  = '{1,   13,  0,   0,   1,  11,  1, 0, 0, 0};
      vecs[8]  = '{1,   14,  0,   0,   1,  11,  0, 0, 0, 0};
      vecs[9]  = '{1,   15,  0,   0,   1,  11,  0, 0, 0, 0};
      vecs[10] = '{1,   16,  0,   0,   1,  11,  0, 0, 0, 0};
      vecs[11] = '{0,   0,   1,   0,   1,  12,  1, 1, 0, 0};
      vecs[12] = '{0,   0,   1,   0,   1,  13,  1, 1, 0, 0};
      vecs[13] = '{0,   0,   1,   0,   1,  14,  1, 1, 0, 0};
      vecs[14] = '{0,   0,   1,   0,   0,  14,  1, 1, 0, 0};
      vecs[15] = '{0,   0,   1,   0,   0,  14,  1, 0, 0, 0};
      vecs[16] = '{1,   100, 0,   0,   1, 100,  1, 0, 0, 0};
      vecs[17] = '{1,   200, 0,   0,   1, 100,  1, 0, 0, 0};
      vecs[18] = '{1,   300, 1,   0,   1, 200,  1, 1, 0, 0};
      vecs[19] = '{0,   0,   1,   0,   1, 300,  1, 1, 0, 0};
      vecs[20] = '{0,   0,   1,   0,   0, 300,  1, 1, 0, 0};
      vecs[21] = '{0,   0,   0,   0,   0, 300,  1, 0, 0, 0};
      vecs[22] = '{0,   0,   0,   1,   0, 300,  1, 0, 0, 1};
      vecs[23] = '{0,   0,   0,   0,   0, 300,  1, 0, 0, 0};

      // Reset state
      do_reset();
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_out_index", int'(out_index), 0);
      check("rst_offset_inc", int'(offset_inc), 0);
      check("rst_offset_clr", int'(offset_clr), 0);
      check("rst_flush_done", int'(flush_done), 0);
`ifdef FLIP_DISPATCH_STATS_EN
      check("rst_flip_count", int'(flip_count), 0);
`endif

      // Table-driven FIFO vectors
      for (int i = 0; i < NVEC; i++) begin
         in_valid  = (vecs[i].iv != 0);
         in_index  = 10'(vecs[i].idx);
         out_ready = (vecs[i].ordy != 0);
         flush     = (vecs[i].fl != 0);
         step();
         check($sformatf("v%0d_out_valid", i), int'(out_valid), vecs[i].ov);
         check($sformatf("v%0d_out_index", i), int'(out_index), vecs[i].oi);
         check($sformatf("v%0d_in_ready", i), int'(in_ready), vecs[i].ir);
         check($sformatf("v%0d_offset_clr", i), int'(offset_clr), vecs[i].clr);
         check($sformatf("v%0d_offset_inc", i), int'(offset_inc), vecs[i].inc);
         check($sformatf("v%0d_flush_done", i), int'(flush_done), vecs[i].fd);
      end
      flush = 1'b0;

      // No-flip counter: 40 idle cycles give pulses after the 16th and 32nd
      do_reset();
      out_ready = 1'b1;
      npulse = 0;
      for (int c = 1; c <= 40; c++) begin
         step();
         check($sformatf("noflip_c%0d", c), int'(offset_inc), (c == 16 || c == 32) ? 1 : 0);
         if (offset_inc) npulse++;
      end
      check("noflip_pulse_count", npulse, 2);

      // A candidate at cycle 10 restarts the count
      do_reset();
      out_ready = 1'b1;
      in_index = 10'd7;
      for (int c = 1; c <= 26; c++) begin
         in_valid = (c == 10);
         step();
         check($sformatf("restart_c%0d", c), int'(offset_inc), (c == 26) ? 1 : 0);
      end
      in_valid = 1'b0;

      // Flush with three queued entries
      do_reset();
      push_n(3, 21);
      check("drain_pre_count", int'(out_index), 21);
      flush = 1'b1;
      out_ready = 1'b1;
      nclr = 0;
      nfd = 0;
      step();
      flush = 1'b0;
      in_valid = 1'b1;
      in_index = 10'd99;
      check("drain_e0_in_ready", int'(in_ready), 0);
      check("drain_e0_out_index", int'(out_index), 22);
      nclr += int'(offset_clr);
      nfd += int'(flush_done);
      step();
      check("drain_e1_out_index", int'(out_index), 23);
      check("drain_e1_in_ready", int'(in_ready), 0);
      nclr += int'(offset_clr);
      nfd += int'(flush_done);
      step();
      check("drain_e2_out_valid", int'(out_valid), 0);
      check("drain_e2_flush_done", int'(flush_done), 0);
      nclr += int'(offset_clr);
      step();
      in_valid = 1'b0;
      check("drain_e3_flush_done", int'(flush_done), 1);
      check("drain_e3_in_ready", int'(in_ready), 1);
      check("drain_e3_out_valid", int'(out_valid), 0);
      nclr += int'(offset_clr);
      nfd += int'(flush_done);
      for (int k = 0; k < 4; k++) begin
         step();
         nclr += int'(offset_clr);
         nfd += int'(flush_done);
      end
      check("drain_clr_pulses", nclr, 3);
      check("drain_done_pulses", nfd, 1);

      // Reset during DRAIN with two entries still queued
      do_reset();
      push_n(3, 40);
      flush = 1'b1;
      step();
      flush = 1'b0;
      out_ready = 1'b1;
      step();
      check("rdrain_pre_out_valid", int'(out_valid), 1);
      check("rdrain_pre_in_ready", int'(in_ready), 0);
      rst_n = 1'b0;
      out_ready = 1'b0;
      step();
      rst_n = 1'b1;
      check("rdrain_out_valid", int'(out_valid), 0);
      check("rdrain_in_ready", int'(in_ready), 1);
      check("rdrain_flush_done", int'(flush_done), 0);
      check("rdrain_out_index", int'(out_index), 0);
      step();
      check("rdrain_post_flush_done", int'(flush_done), 0);
      check("rdrain_post_out_valid", int'(out_valid), 0);

`ifdef FLIP_DISPATCH_STATS_EN
      // Saturation of the pop counter
      do_reset();
      in_valid = 1'b1;
      in_index = 10'd1;
      out_ready = 1'b1;
      for (int k = 0; k < 70010; k++) @(posedge clk);
      #1;
      check("stats_saturate", int'(flip_count), 16'hFFFF);
      in_valid = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
